// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    localparam int unsigned UartDataBits = 8;

    typedef logic [UartDataBits-1:0] uart_byte_t;

    // StParity is declared in every build so state encodings match across configurations.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; both flops reset to 0.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte AXI-stream output register.
// Even parity (11-bit frame) is enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CyclesPerBit = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       tready,
    output logic       tvalid,
    output logic [7:0] tdata,
    output logic       overflow,
    output logic       framing_error,
    output logic       parity_error
);

    localparam int unsigned CntW = $clog2(CyclesPerBit);
    localparam logic [CntW-1:0] BitLast  = CntW'(CyclesPerBit - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CyclesPerBit / 2 - 1);
    localparam logic [2:0]      IdxLast  = 3'(UartDataBits - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    uart_rx_state_t  state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]      idx_q, idx_d;
    uart_byte_t      shift_q, shift_d;
    logic            line_armed_q, line_armed_d;
    logic            tvalid_q, tvalid_d;
    uart_byte_t      tdata_q, tdata_d;
    logic            overflow_q, overflow_d;
    logic            framing_q, framing_d;
    logic            parity_q, parity_d;
    logic            deliver;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q + 1'b1;
        idx_d        = idx_q;
        shift_d      = shift_q;
        line_armed_d = line_armed_q;
        tvalid_d     = tvalid_q & ~tready;
        tdata_d      = tdata_q;
        overflow_d   = 1'b0;
        framing_d    = 1'b0;
        parity_d     = 1'b0;
        deliver      = 1'b0;

        // Only a high line seen while idle may arm start detection.
        if (state_q == StIdle && rx_s) begin
            line_armed_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (line_armed_q && !rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_cnt_q == HalfLast) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_cnt_q == BitLast) begin
                    bit_cnt_d      = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
            StParity: begin
`ifdef UART_RX_PARITY_EN
                if (bit_cnt_q == BitLast) begin
                    bit_cnt_d = '0;
                    if (rx_s != ^shift_q) begin
                        parity_d     = 1'b1;
                        line_armed_d = 1'b0;
                        state_d      = StIdle;
                    end else begin
                        state_d = StStop;
                    end
                end
`else
                state_d = StIdle;
`endif
            end
            StStop: begin
                if (bit_cnt_q == BitLast) begin
                    bit_cnt_d = '0;
                    state_d   = StIdle;
                    if (rx_s) begin
                        deliver = 1'b1;
                    end else begin
                        framing_d    = 1'b1;
                        line_armed_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A held byte being accepted this edge frees the slot for the new one.
        if (deliver) begin
            if (!tvalid_q || tready) begin
                tvalid_d = 1'b1;
                tdata_d  = shift_q;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            line_armed_q <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            overflow_q   <= 1'b0;
            framing_q    <= 1'b0;
            parity_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            line_armed_q <= line_armed_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            overflow_q   <= overflow_d;
            framing_q    <= framing_d;
            parity_q     <= parity_d;
        end
    end

    assign tvalid        = tvalid_q;
    assign tdata         = tdata_q;
    assign overflow      = overflow_q;
    assign framing_error = framing_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule
